// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong types and constants
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        POINT,
        OVER
    } game_state_t;

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - vsync synchroniser with one-cycle falling-edge frame pulse
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);

    logic sync1;
    logic sync2;
    logic prev;

    // Flops reset high so an idle-high vsync never produces a spurious tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            prev       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            sync1      <= vsync;
            sync2      <= sync1;
            prev       <= sync2;
            frame_tick <= prev & ~sync2;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - Pong match sequencer: serve pacing, point pauses, scores, winner
module game_ctrl
    import pong_pkg::*;
#(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               start,
    input  logic               p1_point,
    input  logic               p2_point,
    output logic               ball_hold,
    output logic               ball_run,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               game_over,
    output logic               winner,
    output logic               frame_tick
);

    localparam int CNT_W = $clog2(max_int(SERVE_FRAMES, POINT_FRAMES)) + 1;
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    game_state_t        state;
    logic [CNT_W-1:0]   frame_cnt;
    logic [SCORE_W-1:0] p1_next;
    logic [SCORE_W-1:0] p2_next;

    assign p1_next = score_p1 + SCORE_W'(1);
    assign p2_next = score_p2 + SCORE_W'(1);

    frame_tick_gen u_frame_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            frame_cnt <= '0;
            score_p1  <= '0;
            score_p2  <= '0;
            serve_dir <= PLAYER1;
            game_over <= 1'b0;
            winner    <= PLAYER1;
            ball_hold <= 1'b1;
            ball_run  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SERVE;
                        score_p1  <= '0;
                        score_p2  <= '0;
                        frame_cnt <= '0;
                    end
                end
                SERVE: begin
                    if (frame_tick) begin
                        if (frame_cnt == SERVE_LAST) begin
                            state     <= PLAY;
                            frame_cnt <= '0;
                            ball_hold <= 1'b0;
                            ball_run  <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end
                PLAY: begin
                    // Simultaneous goals are treated as a replay: no score, same server.
                    if (p1_point && p2_point) begin
                        state     <= POINT;
                        ball_hold <= 1'b1;
                        ball_run  <= 1'b0;
                    end else if (p1_point) begin
                        score_p1  <= p1_next;
                        serve_dir <= PLAYER2;
                        ball_hold <= 1'b1;
                        ball_run  <= 1'b0;
                        if (p1_next == WIN_VAL) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                            winner    <= PLAYER1;
                        end else begin
                            state <= POINT;
                        end
                    end else if (p2_point) begin
                        score_p2  <= p2_next;
                        serve_dir <= PLAYER1;
                        ball_hold <= 1'b1;
                        ball_run  <= 1'b0;
                        if (p2_next == WIN_VAL) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                            winner    <= PLAYER2;
                        end else begin
                            state <= POINT;
                        end
                    end
                end
                POINT: begin
                    if (frame_tick) begin
                        if (frame_cnt == POINT_LAST) begin
                            state     <= SERVE;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end
                OVER: begin
                    if (start) begin
                        state     <= SERVE;
                        score_p1  <= '0;
                        score_p2  <= '0;
                        frame_cnt <= '0;
                        game_over <= 1'b0;
                        serve_dir <= ~winner;
                    end
                end
                default: begin
                    state     <= IDLE;
                    frame_cnt <= '0;
                    ball_hold <= 1'b1;
                    ball_run  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - randomized self-checking bench for game_ctrl against a rule-level match model
module tb_game_ctrl;

    localparam int SCORE_W      = 4;
    localparam int WIN_SCORE    = 7;
    localparam int SERVE_FRAMES = 60;
    localparam int POINT_FRAMES = 90;

    logic               clk = 1'b0;
    logic               reset;
    logic               vsync;
    logic               start;
    logic               p1_point;
    logic               p2_point;
    logic               ball_hold;
    logic               ball_run;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic               game_over;
    logic               winner;
    logic               frame_tick;

    logic [12:0] act;
    assign act = {ball_hold, ball_run, serve_dir, score_p1, score_p2, game_over, winner};

    int passed = 0;
    int total  = 0;

    game_ctrl #(
        .SCORE_W      (SCORE_W),
        .WIN_SCORE    (WIN_SCORE),
        .SERVE_FRAMES (SERVE_FRAMES),
        .POINT_FRAMES (POINT_FRAMES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .start      (start),
        .p1_point   (p1_point),
        .p2_point   (p2_point),
        .ball_hold  (ball_hold),
        .ball_run   (ball_run),
        .serve_dir  (serve_dir),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .game_over  (game_over),
        .winner     (winner),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Match model: phase plus frame count, driven by events (frame, goal, start).
    typedef enum {M_IDLE, M_SERVE, M_PLAY, M_POINT, M_OVER} mphase_t;
    mphase_t m_phase;
    int      m_frames;
    int      m_s1;
    int      m_s2;
    bit      m_dir;
    bit      m_over;
    bit      m_win;

    function automatic void model_reset();
        m_phase = M_IDLE; m_frames = 0; m_s1 = 0; m_s2 = 0;
        m_dir = 1'b0; m_over = 1'b0; m_win = 1'b0;
    endfunction

    function automatic void model_frame();
        if (m_phase == M_SERVE) begin
            m_frames++;
            if (m_frames == SERVE_FRAMES) begin m_phase = M_PLAY; m_frames = 0; end
        end else if (m_phase == M_POINT) begin
            m_frames++;
            if (m_frames == POINT_FRAMES) begin m_phase = M_SERVE; m_frames = 0; end
        end
    endfunction

    function automatic void model_point(input bit a, input bit b);
        if (m_phase != M_PLAY || (!a && !b)) return;
        if (a && b) begin
            m_phase = M_POINT;
        end else if (a) begin
            m_s1++; m_dir = 1'b1;
            if (m_s1 == WIN_SCORE) begin m_phase = M_OVER; m_over = 1'b1; m_win = 1'b0; end
            else m_phase = M_POINT;
        end else begin
            m_s2++; m_dir = 1'b0;
            if (m_s2 == WIN_SCORE) begin m_phase = M_OVER; m_over = 1'b1; m_win = 1'b1; end
            else m_phase = M_POINT;
        end
        m_frames = 0;
    endfunction

    function automatic void model_start();
        if (m_phase == M_IDLE || m_phase == M_OVER) begin
            if (m_phase == M_OVER) begin m_dir = !m_win; m_over = 1'b0; end
            m_phase = M_SERVE; m_frames = 0; m_s1 = 0; m_s2 = 0;
        end
    endfunction

    function automatic logic [12:0] exp_vec();
        return {m_phase != M_PLAY, m_phase == M_PLAY, m_dir, 4'(m_s1), 4'(m_s2), m_over, m_win};
    endfunction

    // One vsync pulse; returns tick count and the outputs one cycle after the tick.
    task automatic frame(input int gap, output int ticks, output logic [12:0] after);
        bit seen;
        ticks = 0; seen = 1'b0; after = act;
        vsync = 1'b0;
        for (int c = 0; c < 4 + gap; c++) begin
            if (c == 4) vsync = 1'b1;
            @(negedge clk);
            if (seen) after = act;
            seen = frame_tick;
            if (frame_tick) ticks++;
        end
    endtask

    task automatic pulse(input bit a, input bit b);
        p1_point = a; p2_point = b;
        @(negedge clk);
        p1_point = 1'b0; p2_point = 1'b0;
        model_point(a, b);
    endtask

    // Counts frames whose tick count or post-tick outputs disagree with the model.
    task automatic run_frames(input int n, input bit noise, output int bad);
        int          t;
        logic [12:0] a;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (noise && m_phase != M_PLAY && $urandom_range(0, 5) == 0)
                pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            frame($urandom_range(3, 12), t, a);
            model_frame();
            if (t != 1 || a !== exp_vec()) bad++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; vsync = 1'b1; start = 1'b0; p1_point = 1'b0; p2_point = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (act !== exp_vec()) $display("FAIL reset_outputs: got %h exp %h", act, exp_vec());
        else passed++;
        total++;
        if (frame_tick !== 1'b0) $display("FAIL reset_tick: got %b exp 0", frame_tick);
        else passed++;
    endtask

    task automatic test_idle_frames();
        int          t;
        logic [12:0] a;
        for (int i = 0; i < 4; i++) begin
            frame(996, t, a);
            model_frame();
            total++;
            if (t != 1 || act !== exp_vec())
                $display("FAIL idle_frame%0d: ticks %0d outs %h exp ticks 1 outs %h", i, t, act, exp_vec());
            else passed++;
        end
    endtask

    task automatic test_serve();
        int          bad;
        int          t;
        logic [12:0] a;
        start = 1'b1;
        @(negedge clk);
        model_start();
        total++;
        if (act !== exp_vec()) $display("FAIL serve_enter: got %h exp %h", act, exp_vec());
        else passed++;
        run_frames(SERVE_FRAMES - 1, 1'b0, bad);
        total++;
        if (bad !== 0 || ball_run !== 1'b0 || ball_hold !== 1'b1)
            $display("FAIL serve_59: bad %0d run %b hold %b exp 0 0 1", bad, ball_run, ball_hold);
        else passed++;
        frame(5, t, a);
        model_frame();
        total++;
        if (t != 1 || a !== exp_vec() || a[11] !== 1'b1 || a[12] !== 1'b0)
            $display("FAIL serve_launch: ticks %0d got %h exp %h", t, a, exp_vec());
        else passed++;
        start = 1'b0;
    endtask

    task automatic test_point_p1();
        int          bad;
        int          t;
        logic [12:0] a;
        pulse(1'b1, 1'b0);
        total++;
        if (act !== exp_vec() || score_p1 !== 4'd1 || serve_dir !== 1'b1)
            $display("FAIL p1_point: got %h exp %h", act, exp_vec());
        else passed++;
        run_frames(POINT_FRAMES - 1, 1'b1, bad);
        total++;
        if (bad !== 0 || ball_hold !== 1'b1 || act !== exp_vec())
            $display("FAIL point_pause: bad %0d got %h exp %h", bad, act, exp_vec());
        else passed++;
        frame(6, t, a);
        model_frame();
        total++;
        if (t != 1 || a !== exp_vec()) $display("FAIL point_to_serve: got %h exp %h", a, exp_vec());
        else passed++;
        run_frames(SERVE_FRAMES, 1'b1, bad);
        total++;
        if (bad !== 0 || act !== exp_vec() || ball_run !== 1'b1)
            $display("FAIL reserve_play: bad %0d got %h exp %h", bad, act, exp_vec());
        else passed++;
    endtask

    task automatic test_both();
        int bad;
        pulse(1'b1, 1'b1);
        total++;
        if (act !== exp_vec() || ball_hold !== 1'b1)
            $display("FAIL both_points: got %h exp %h", act, exp_vec());
        else passed++;
        run_frames(POINT_FRAMES + SERVE_FRAMES, 1'b1, bad);
        total++;
        if (bad !== 0 || act !== exp_vec())
            $display("FAIL both_replay: bad %0d got %h exp %h", bad, act, exp_vec());
        else passed++;
    endtask

    task automatic test_p2_wins();
        int bad;
        for (int k = 0; k < WIN_SCORE; k++) begin
            pulse(1'b0, 1'b1);
            total++;
            if (act !== exp_vec()) $display("FAIL p2_point%0d: got %h exp %h", k, act, exp_vec());
            else passed++;
            if (m_phase != M_OVER) begin
                run_frames(POINT_FRAMES + SERVE_FRAMES, 1'b1, bad);
                total++;
                if (bad !== 0) $display("FAIL p2_rally%0d: bad frames %0d exp 0", k, bad);
                else passed++;
            end
        end
        total++;
        if (game_over !== 1'b1 || winner !== 1'b1 || score_p2 !== 4'd7)
            $display("FAIL p2_win: over %b winner %b score_p2 %0d exp 1 1 7", game_over, winner, score_p2);
        else passed++;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        run_frames(3, 1'b0, bad);
        total++;
        if (bad !== 0 || act !== exp_vec())
            $display("FAIL over_frozen: bad %0d got %h exp %h", bad, act, exp_vec());
        else passed++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_start();
        total++;
        if (act !== exp_vec() || serve_dir !== 1'b0 || game_over !== 1'b0)
            $display("FAIL restart: got %h exp %h", act, exp_vec());
        else passed++;
        run_frames(SERVE_FRAMES, 1'b1, bad);
        total++;
        if (bad !== 0 || act !== exp_vec())
            $display("FAIL restart_serve: bad %0d got %h exp %h", bad, act, exp_vec());
        else passed++;
    endtask

    task automatic test_reset_mid();
        int bad;
        int seq[5];
        int j;
        int tmp;
        seq = '{1, 1, 1, 2, 2};
        for (int i = 4; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = seq[i]; seq[i] = seq[j]; seq[j] = tmp;
        end
        for (int i = 0; i < 5; i++) begin
            pulse(seq[i] == 1, seq[i] == 2);
            run_frames(POINT_FRAMES + SERVE_FRAMES, 1'b1, bad);
            total++;
            if (bad !== 0 || act !== exp_vec())
                $display("FAIL rally%0d: bad %0d got %h exp %h", i, bad, act, exp_vec());
            else passed++;
        end
        total++;
        if (score_p1 !== 4'd3 || score_p2 !== 4'd2 || ball_run !== 1'b1)
            $display("FAIL score_3_2: p1 %0d p2 %0d run %b exp 3 2 1", score_p1, score_p2, ball_run);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        total++;
        if (act !== exp_vec() || frame_tick !== 1'b0)
            $display("FAIL reset_mid: got %h tick %b exp %h tick 0", act, frame_tick, exp_vec());
        else passed++;
        reset = 1'b0;
        run_frames(2, 1'b0, bad);
        total++;
        if (bad !== 0 || act !== exp_vec())
            $display("FAIL idle_after_reset: bad %0d got %h exp %h", bad, act, exp_vec());
        else passed++;
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b1; start = 1'b0; p1_point = 1'b0; p2_point = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_idle_frames();
        test_serve();
        test_point_p1();
        test_both();
        test_p2_wins();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
